// File: rtl/tl2axil_bridge_if.sv
// Bus bundle between the TileLink-UL initiator, the tl2axil_bridge and the AXI4-Lite peripheral.
// The master modport is the bridge's view: TL responder on one side, AXI master on the other.
interface tl2axil_bridge_if #(
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SOURCE_WIDTH = 9
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic                    tl_a_ready;
  logic                    tl_a_valid;
  logic [2:0]              tl_a_opcode;
  logic [2:0]              tl_a_param;
  logic [1:0]              tl_a_size;
  logic [SOURCE_WIDTH-1:0] tl_a_source;
  logic [ADDR_WIDTH-1:0]   tl_a_address;
  logic [StrbWidth-1:0]    tl_a_mask;
  logic [DATA_WIDTH-1:0]   tl_a_data;
  logic                    tl_a_corrupt;

  logic                    tl_d_ready;
  logic                    tl_d_valid;
  logic [2:0]              tl_d_opcode;
  logic [1:0]              tl_d_size;
  logic [SOURCE_WIDTH-1:0] tl_d_source;
  logic                    tl_d_denied;
  logic [DATA_WIDTH-1:0]   tl_d_data;

  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [StrbWidth-1:0]    M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    output tl_a_ready,
    input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
    input  tl_a_mask, tl_a_data, tl_a_corrupt,
    input  tl_d_ready,
    output tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_denied, tl_d_data,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  tl_a_ready,
    output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address,
    output tl_a_mask, tl_a_data, tl_a_corrupt,
    output tl_d_ready,
    input  tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_denied, tl_d_data,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/tl2axil_bridge.sv
// TileLink-UL responder to AXI4-Lite master bridge, one transaction in flight, registered outputs.
// Optional response timeout with post-timeout drain: define TL2AXIL_TIMEOUT_EN.
module tl2axil_bridge #(
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned SOURCE_WIDTH   = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESETN,
  tl2axil_bridge_if.master bus
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWr    = 3'd1;
  localparam logic [2:0] StBWait = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StRWait = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  logic [2:0]              state_q, state_d;
  logic                    a_ready_q, a_ready_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                    bready_q, bready_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
  logic                    d_valid_q, d_valid_d, d_denied_q, d_denied_d;
  logic [2:0]              d_opcode_q, d_opcode_d;
  logic [1:0]              d_size_q, d_size_d;
  logic [SOURCE_WIDTH-1:0] d_source_q, d_source_d;
  logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;

  logic a_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, d_hs;
  assign a_hs  = bus.tl_a_valid & a_ready_q;
  assign aw_hs = awvalid_q & bus.M_AXI_AWREADY;
  assign w_hs  = wvalid_q & bus.M_AXI_WREADY;
  assign ar_hs = arvalid_q & bus.M_AXI_ARREADY;
  assign b_hs  = bready_q & bus.M_AXI_BVALID;
  assign r_hs  = rready_q & bus.M_AXI_RVALID;
  assign d_hs  = d_valid_q & bus.tl_d_ready;

`ifdef TL2AXIL_TIMEOUT_EN
  localparam logic [2:0]  StDrain     = 3'd6;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic        to_q, to_d, b_pend_q, b_pend_d, r_pend_q, r_pend_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy;
  assign busy = (state_q == StWr) || (state_q == StRd) || (state_q == StBWait) ||
                (state_q == StRWait);
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

  logic unused_sigs;
  assign unused_sigs = ^{bus.tl_a_param, bus.M_AXI_BRESP[0], bus.M_AXI_RRESP[0]};

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    d_denied_d = d_denied_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
`ifdef TL2AXIL_TIMEOUT_EN
    to_d       = to_q;
    b_pend_d   = b_pend_q & ~b_hs;
    r_pend_d   = r_pend_q & ~r_hs;
    cnt_d      = cnt_q;
`endif
    // AXI valids fall only on their own handshake, whatever the FSM is doing.
    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs)  wvalid_d  = 1'b0;
    if (ar_hs) arvalid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (a_hs) begin
          d_size_d   = bus.tl_a_size;
          d_source_d = bus.tl_a_source;
          d_data_d   = '0;
          case (bus.tl_a_opcode)
            OpPutFull, OpPutPartial: begin
              if (bus.tl_a_corrupt) begin
                state_d    = StResp;
                d_opcode_d = OpAccessAck;
                d_denied_d = 1'b1;
              end else begin
                state_d   = StWr;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = bus.tl_a_address;
                wdata_d   = bus.tl_a_data;
                wstrb_d   = bus.tl_a_mask;
`ifdef TL2AXIL_TIMEOUT_EN
                b_pend_d  = 1'b1;
`endif
              end
            end
            OpGet: begin
              state_d   = StRd;
              arvalid_d = 1'b1;
              araddr_d  = bus.tl_a_address;
`ifdef TL2AXIL_TIMEOUT_EN
              r_pend_d  = 1'b1;
`endif
            end
            default: begin
              state_d    = StResp;
              d_opcode_d = OpAccessAckData;
              d_denied_d = 1'b1;
            end
          endcase
        end
      end
      StWr:    if (!awvalid_d && !wvalid_d) state_d = StBWait;
      StRd:    if (ar_hs) state_d = StRWait;
      StBWait: begin
        if (b_hs) begin
          state_d    = StResp;
          d_opcode_d = OpAccessAck;
          d_data_d   = '0;
          d_denied_d = bus.M_AXI_BRESP[1];
        end
      end
      StRWait: begin
        if (r_hs) begin
          state_d    = StResp;
          d_opcode_d = OpAccessAckData;
          d_data_d   = bus.M_AXI_RDATA;
          d_denied_d = bus.M_AXI_RRESP[1];
        end
      end
      StResp: begin
        if (d_hs) begin
`ifdef TL2AXIL_TIMEOUT_EN
          state_d = to_q ? StDrain : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef TL2AXIL_TIMEOUT_EN
      StDrain: begin
        if (!awvalid_d && !wvalid_d && !arvalid_d && !b_pend_d && !r_pend_d) begin
          state_d = StIdle;
          to_d    = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef TL2AXIL_TIMEOUT_EN
    // Real progress in the same cycle wins over the timeout.
    if (busy && (state_d == state_q) && (cnt_q == TimeoutLast)) begin
      state_d    = StResp;
      d_opcode_d = ((state_q == StRd) || (state_q == StRWait)) ? OpAccessAckData : OpAccessAck;
      d_data_d   = '0;
      d_denied_d = 1'b1;
      to_d       = 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
    else if (busy)          cnt_d = cnt_q + 16'd1;
`endif

    a_ready_d = (state_d == StIdle);
    d_valid_d = (state_d == StResp);
    bready_d  = (state_d == StBWait);
    rready_d  = (state_d == StRWait);
`ifdef TL2AXIL_TIMEOUT_EN
    if (state_d == StDrain) begin
      bready_d = b_pend_d;
      rready_d = r_pend_d;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= StIdle;
      a_ready_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      d_valid_q  <= 1'b0;
      d_denied_q <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
`ifdef TL2AXIL_TIMEOUT_EN
      to_q       <= 1'b0;
      b_pend_q   <= 1'b0;
      r_pend_q   <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_ready_q  <= a_ready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      bready_q   <= bready_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      d_valid_q  <= d_valid_d;
      d_denied_q <= d_denied_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
`ifdef TL2AXIL_TIMEOUT_EN
      to_q       <= to_d;
      b_pend_q   <= b_pend_d;
      r_pend_q   <= r_pend_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.tl_a_ready    = a_ready_q;
  assign bus.tl_d_valid    = d_valid_q;
  assign bus.tl_d_opcode   = d_opcode_q;
  assign bus.tl_d_size     = d_size_q;
  assign bus.tl_d_source   = d_source_q;
  assign bus.tl_d_denied   = d_denied_q;
  assign bus.tl_d_data     = d_data_q;
  assign bus.M_AXI_AWADDR  = awaddr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARADDR  = araddr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;
endmodule
